// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI memory arbiter.
package axi_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [2:0] PROT_INSN = 3'b100;
    localparam logic [2:0] PROT_DATA = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_RESP,
        DONE
    } arb_state_e;

    // Request captured at grant time and held for the whole AXI transaction
    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/axi_arb_rr.sv
// Two-way grant picker with a pointer register.
// AXI_ARB_RR_EN defined: round-robin, pointer moves to the other requester
// after every grant. Undefined: pointer pinned to requester 0 (fixed priority).
module axi_arb_rr (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_c
);

    logic ptr_q;
    logic ptr_d;

    // Pick the lone requester, or the pointer's choice when both request
    always_comb begin
        gnt_c = 1'b0;
        case (req)
            2'b01:   gnt_c = 1'b0;
            2'b10:   gnt_c = 1'b1;
            2'b11:   gnt_c = ptr_q;
            default: gnt_c = 1'b0;
        endcase
    end

    // Pointer update on each accepted grant
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
`ifdef AXI_ARB_RR_EN
            ptr_d = ~gnt_c;
`else
            ptr_d = 1'b0;
`endif
        end
    end

    // Pointer register, starts at requester 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi_mem_arb2.sv
// Arbitrates two native memory requesters onto one AXI4-Lite master port,
// one outstanding transaction at a time. Arbitration mode via AXI_ARB_RR_EN.
module axi_mem_arb2
    import axi_arb_pkg::*;
#(
    parameter int unsigned INSN_PROT = 1
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m0_mem_valid,
    input  logic              m0_mem_instr,
    input  logic [ADDR_W-1:0] m0_mem_addr,
    input  logic [DATA_W-1:0] m0_mem_wdata,
    input  logic [STRB_W-1:0] m0_mem_wstrb,
    output logic              m0_mem_ready,
    output logic [DATA_W-1:0] m0_mem_rdata,

    input  logic              m1_mem_valid,
    input  logic              m1_mem_instr,
    input  logic [ADDR_W-1:0] m1_mem_addr,
    input  logic [DATA_W-1:0] m1_mem_wdata,
    input  logic [STRB_W-1:0] m1_mem_wstrb,
    output logic              m1_mem_ready,
    output logic [DATA_W-1:0] m1_mem_rdata,

    output logic              mem_axi_awvalid,
    input  logic              mem_axi_awready,
    output logic [ADDR_W-1:0] mem_axi_awaddr,
    output logic [2:0]        mem_axi_awprot,

    output logic              mem_axi_wvalid,
    input  logic              mem_axi_wready,
    output logic [DATA_W-1:0] mem_axi_wdata,
    output logic [STRB_W-1:0] mem_axi_wstrb,

    input  logic              mem_axi_bvalid,
    output logic              mem_axi_bready,

    output logic              mem_axi_arvalid,
    input  logic              mem_axi_arready,
    output logic [ADDR_W-1:0] mem_axi_araddr,
    output logic [2:0]        mem_axi_arprot,

    input  logic              mem_axi_rvalid,
    output logic              mem_axi_rready,
    input  logic [DATA_W-1:0] mem_axi_rdata
);

    arb_state_e        state_q, state_d;
    mem_req_t          req_q, req_d, sel_c;
    logic              grant_q, grant_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [1:0]        ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              gnt_c;
    logic              advance_c;

    assign advance_c = (state_q == IDLE) && (m0_mem_valid || m1_mem_valid);

    axi_arb_rr u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     ({m1_mem_valid, m0_mem_valid}),
        .advance (advance_c),
        .gnt_c   (gnt_c)
    );

    // Request fields of the requester the picker currently favours
    always_comb begin
        sel_c.instr = gnt_c ? m1_mem_instr : m0_mem_instr;
        sel_c.addr  = gnt_c ? m1_mem_addr  : m0_mem_addr;
        sel_c.wdata = gnt_c ? m1_mem_wdata : m0_mem_wdata;
        sel_c.wstrb = gnt_c ? m1_mem_wstrb : m0_mem_wstrb;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        grant_d   = grant_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
        ready_d   = 2'b00;

        case (state_q)
            IDLE: begin
                if (advance_c) begin
                    grant_d = gnt_c;
                    req_d   = sel_c;
                    if (sel_c.wstrb != '0) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                // Address and data channels retire independently
                if (awvalid_q && mem_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && mem_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)      state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (mem_axi_bvalid) state_d = DONE;
            end
            RD: begin
                if (mem_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (mem_axi_rvalid) begin
                    rdata_d = mem_axi_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bready_d = (state_d == WR_RESP);
        rready_d = (state_d == RD_RESP);
        if (state_d == DONE) ready_d[grant_d] = 1'b1;
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            req_q     <= '0;
            grant_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            grant_q   <= grant_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = req_q.addr;
    assign mem_axi_awprot  = PROT_DATA;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = req_q.wdata;
    assign mem_axi_wstrb   = req_q.wstrb;
    assign mem_axi_bready  = bready_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = req_q.addr;
    assign mem_axi_arprot  = ((INSN_PROT != 0) && req_q.instr) ? PROT_INSN : PROT_DATA;
    assign mem_axi_rready  = rready_q;

    assign m0_mem_ready = ready_q[0];
    assign m1_mem_ready = ready_q[1];
    assign m0_mem_rdata = rdata_q;
    assign m1_mem_rdata = rdata_q;

endmodule

// File: tb/tb_axi_mem_arb2.sv
// Directed bench for axi_mem_arb2 with a small AXI4-Lite slave model.
// Arbitration expectations follow AXI_ARB_RR_EN as compiled.
module tb_axi_mem_arb2;

    logic        clk;
    logic        resetn;

    logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
    logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
    logic [3:0]  m0_mem_wstrb;
    logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
    logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
    logic [3:0]  m1_mem_wstrb;

    logic        mem_axi_awvalid, mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid, mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid, mem_axi_bready;
    logic        mem_axi_arvalid, mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid, mem_axi_rready;
    logic [31:0] mem_axi_rdata;

    int checks;
    int failures;

    axi_mem_arb2 dut (
        .clk             (clk),
        .resetn          (resetn),
        .m0_mem_valid    (m0_mem_valid),
        .m0_mem_instr    (m0_mem_instr),
        .m0_mem_addr     (m0_mem_addr),
        .m0_mem_wdata    (m0_mem_wdata),
        .m0_mem_wstrb    (m0_mem_wstrb),
        .m0_mem_ready    (m0_mem_ready),
        .m0_mem_rdata    (m0_mem_rdata),
        .m1_mem_valid    (m1_mem_valid),
        .m1_mem_instr    (m1_mem_instr),
        .m1_mem_addr     (m1_mem_addr),
        .m1_mem_wdata    (m1_mem_wdata),
        .m1_mem_wstrb    (m1_mem_wstrb),
        .m1_mem_ready    (m1_mem_ready),
        .m1_mem_rdata    (m1_mem_rdata),
        .mem_axi_awvalid (mem_axi_awvalid),
        .mem_axi_awready (mem_axi_awready),
        .mem_axi_awaddr  (mem_axi_awaddr),
        .mem_axi_awprot  (mem_axi_awprot),
        .mem_axi_wvalid  (mem_axi_wvalid),
        .mem_axi_wready  (mem_axi_wready),
        .mem_axi_wdata   (mem_axi_wdata),
        .mem_axi_wstrb   (mem_axi_wstrb),
        .mem_axi_bvalid  (mem_axi_bvalid),
        .mem_axi_bready  (mem_axi_bready),
        .mem_axi_arvalid (mem_axi_arvalid),
        .mem_axi_arready (mem_axi_arready),
        .mem_axi_araddr  (mem_axi_araddr),
        .mem_axi_arprot  (mem_axi_arprot),
        .mem_axi_rvalid  (mem_axi_rvalid),
        .mem_axi_rready  (mem_axi_rready),
        .mem_axi_rdata   (mem_axi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          aw_delay;
    int          rd_delay;
    logic [31:0] mem_word;
    int          aw_cnt;
    logic        aw_got, w_got;
    int          aw_hs_cnt, w_hs_cnt, ar_hs_cnt;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_arprot, cap_awprot;
    logic        r_pend;
    int          r_cnt;
    int          m0_rdy_cnt, m1_rdy_cnt;

    assign mem_axi_awready = mem_axi_awvalid && (aw_cnt >= aw_delay);
    assign mem_axi_wready  = 1'b1;
    assign mem_axi_arready = 1'b1;

    // Count cycles awvalid waits, for the delayed awready
    always @(posedge clk or negedge resetn) begin
        if (!resetn) aw_cnt <= 0;
        else if (mem_axi_awvalid && !mem_axi_awready) aw_cnt <= aw_cnt + 1;
        else aw_cnt <= 0;
    end

    // Write channels: capture handshakes, answer with one bvalid
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_bvalid <= 1'b0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_hs_cnt <= 0;
            w_hs_cnt  <= 0;
            cap_awaddr <= '0;
            cap_awprot <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
        end else begin
            if (mem_axi_awvalid && mem_axi_awready) begin
                aw_hs_cnt  <= aw_hs_cnt + 1;
                cap_awaddr <= mem_axi_awaddr;
                cap_awprot <= mem_axi_awprot;
            end
            if (mem_axi_wvalid && mem_axi_wready) begin
                w_hs_cnt  <= w_hs_cnt + 1;
                cap_wdata <= mem_axi_wdata;
                cap_wstrb <= mem_axi_wstrb;
            end
            if (mem_axi_bvalid && mem_axi_bready) mem_axi_bvalid <= 1'b0;
            if ((aw_got || (mem_axi_awvalid && mem_axi_awready)) &&
                (w_got  || (mem_axi_wvalid && mem_axi_wready))) begin
                mem_axi_bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got || (mem_axi_awvalid && mem_axi_awready);
                w_got  <= w_got  || (mem_axi_wvalid && mem_axi_wready);
            end
        end
    end

    // Read channels: rvalid right after the ar handshake, or rd_delay later
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= '0;
            r_pend <= 1'b0;
            r_cnt  <= 0;
            ar_hs_cnt  <= 0;
            cap_araddr <= '0;
            cap_arprot <= '0;
        end else begin
            if (mem_axi_rvalid && mem_axi_rready) mem_axi_rvalid <= 1'b0;
            if (mem_axi_arvalid && mem_axi_arready) begin
                ar_hs_cnt  <= ar_hs_cnt + 1;
                cap_araddr <= mem_axi_araddr;
                cap_arprot <= mem_axi_arprot;
                if (rd_delay == 0) begin
                    mem_axi_rvalid <= 1'b1;
                    mem_axi_rdata  <= mem_word;
                end else begin
                    r_pend <= 1'b1;
                    r_cnt  <= rd_delay - 1;
                end
            end else if (r_pend) begin
                if (r_cnt == 0) begin
                    mem_axi_rvalid <= 1'b1;
                    mem_axi_rdata  <= mem_word;
                    r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
        end
    end

    // Ready pulse counters (each pulse is one cycle wide)
    initial begin
        m0_rdy_cnt = 0;
        m1_rdy_cnt = 0;
    end
    always @(negedge clk) begin
        if (m0_mem_ready === 1'b1) m0_rdy_cnt = m0_rdy_cnt + 1;
        if (m1_mem_ready === 1'b1) m1_rdy_cnt = m1_rdy_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue one request from requester m; cyc = cycle ready seen (request cycle is 1)
    task automatic run_txn(input int m, input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input bit drop,
                           output int cyc, output bit ok, output logic [31:0] rd);
        if (m == 0) begin
            m0_mem_valid = 1'b1; m0_mem_instr = instr; m0_mem_addr = addr;
            m0_mem_wdata = wdata; m0_mem_wstrb = wstrb;
        end else begin
            m1_mem_valid = 1'b1; m1_mem_instr = instr; m1_mem_addr = addr;
            m1_mem_wdata = wdata; m1_mem_wstrb = wstrb;
        end
        cyc = 1;
        ok  = 1'b0;
        rd  = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            cyc++;
            if (drop && cyc == 2) begin
                if (m == 0) m0_mem_valid = 1'b0; else m1_mem_valid = 1'b0;
            end
            if (((m == 0) ? m0_mem_ready : m1_mem_ready) === 1'b1) begin
                ok = 1'b1;
                rd = (m == 0) ? m0_mem_rdata : m1_mem_rdata;
            end
        end
        if (m == 0) m0_mem_valid = 1'b0; else m1_mem_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          cyc;
        bit          ok;
        logic [31:0] rd;
        int          s0, s1, saw, sw;
        int          seq[4];
        int          exp_seq[4];
        bit          got;

`ifdef AXI_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        checks = 0;
        failures = 0;
        aw_delay = 0;
        rd_delay = 0;
        mem_word = '0;
        resetn = 1'b0;
        m0_mem_valid = 1'b0; m0_mem_instr = 1'b0; m0_mem_addr = '0; m0_mem_wdata = '0; m0_mem_wstrb = '0;
        m1_mem_valid = 1'b0; m1_mem_instr = 1'b0; m1_mem_addr = '0; m1_mem_wdata = '0; m1_mem_wstrb = '0;

        // Reset state
        repeat (3) tick();
        check("rst_awvalid", 32'(mem_axi_awvalid), 32'd0);
        check("rst_wvalid",  32'(mem_axi_wvalid),  32'd0);
        check("rst_arvalid", 32'(mem_axi_arvalid), 32'd0);
        check("rst_bready",  32'(mem_axi_bready),  32'd0);
        check("rst_rready",  32'(mem_axi_rready),  32'd0);
        check("rst_m0_ready", 32'(m0_mem_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_mem_ready), 32'd0);
        check("rst_rdata", m0_mem_rdata, 32'd0);
        resetn = 1'b1;
        repeat (2) tick();

        // m0 instruction read, zero-wait slave
        mem_word = 32'hDEADBEEF;
        s0 = m0_rdy_cnt; s1 = m1_rdy_cnt;
        run_txn(0, 1'b1, 32'h0000_0100, 32'h0, 4'b0000, 1'b0, cyc, ok, rd);
        check("rd_done", 32'(ok), 32'd1);
        check("rd_latency", 32'(cyc), 32'd4);
        check("rd_rdata", rd, 32'hDEADBEEF);
        check("rd_arprot", 32'(cap_arprot), 32'h4);
        check("rd_araddr", cap_araddr, 32'h0000_0100);
        repeat (3) tick();
        check("rd_m0_pulses", 32'(m0_rdy_cnt - s0), 32'd1);
        check("rd_m1_pulses", 32'(m1_rdy_cnt - s1), 32'd0);
        check("rd_m1_shared_rdata", m1_mem_rdata, 32'hDEADBEEF);

        // m1 write, awready 3 cycles late, wready immediate
        aw_delay = 3;
        s0 = m0_rdy_cnt; s1 = m1_rdy_cnt; saw = aw_hs_cnt; sw = w_hs_cnt;
        run_txn(1, 1'b0, 32'h0000_0040, 32'h12345678, 4'b0011, 1'b0, cyc, ok, rd);
        check("wr_done", 32'(ok), 32'd1);
        check("wr_latency", 32'(cyc), 32'd7);
        repeat (3) tick();
        check("wr_aw_count", 32'(aw_hs_cnt - saw), 32'd1);
        check("wr_w_count",  32'(w_hs_cnt - sw),   32'd1);
        check("wr_awaddr", cap_awaddr, 32'h0000_0040);
        check("wr_awprot", 32'(cap_awprot), 32'd0);
        check("wr_wdata", cap_wdata, 32'h12345678);
        check("wr_wstrb", 32'(cap_wstrb), 32'h3);
        check("wr_m1_pulses", 32'(m1_rdy_cnt - s1), 32'd1);
        check("wr_m0_pulses", 32'(m0_rdy_cnt - s0), 32'd0);
        check("wr_rdata_held", m1_mem_rdata, 32'hDEADBEEF);

        // m0 write, aw and w accepted in the same cycle
        aw_delay = 0;
        run_txn(0, 1'b0, 32'h0000_0080, 32'hA5A5_5A5A, 4'b1111, 1'b0, cyc, ok, rd);
        check("wr_same_cycle_latency", 32'(cyc), 32'd4);
        repeat (2) tick();
        check("wr_same_cycle_wdata", cap_wdata, 32'hA5A5_5A5A);

        // Both requesters held valid: grant order depends on arbitration mode
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        mem_word = 32'h1111_2222;
        m0_mem_addr = 32'h200; m0_mem_wstrb = 4'b0; m0_mem_instr = 1'b0;
        m1_mem_addr = 32'h300; m1_mem_wstrb = 4'b0; m1_mem_instr = 1'b0;
        m0_mem_valid = 1'b1;
        m1_mem_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            seq[g] = -1;
            for (int i = 0; i < 20 && !got; i++) begin
                tick();
                if (m0_mem_ready === 1'b1) begin seq[g] = 0; got = 1'b1; end
                else if (m1_mem_ready === 1'b1) begin seq[g] = 1; got = 1'b1; end
            end
        end
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
        check("arb_grant0", 32'(seq[0]), 32'(exp_seq[0]));
        check("arb_grant1", 32'(seq[1]), 32'(exp_seq[1]));
        check("arb_grant2", 32'(seq[2]), 32'(exp_seq[2]));
        check("arb_grant3", 32'(seq[3]), 32'(exp_seq[3]));
        repeat (3) tick();

        // Reset while waiting in RD_RESP abandons the read
        rd_delay = 5;
        m0_mem_valid = 1'b1; m0_mem_instr = 1'b0; m0_mem_addr = 32'h500; m0_mem_wstrb = 4'b0;
        repeat (2) tick();
        check("rst_mid_rready_before", 32'(mem_axi_rready), 32'd1);
        s0 = m0_rdy_cnt; s1 = m1_rdy_cnt;
        resetn = 1'b0;
        m0_mem_valid = 1'b0;
        #1;
        check("rst_mid_arvalid", 32'(mem_axi_arvalid), 32'd0);
        check("rst_mid_rready",  32'(mem_axi_rready),  32'd0);
        check("rst_mid_rdata",   m0_mem_rdata, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (8) tick();
        check("rst_mid_no_pulse_m0", 32'(m0_rdy_cnt - s0), 32'd0);
        check("rst_mid_no_pulse_m1", 32'(m1_rdy_cnt - s1), 32'd0);
        rd_delay = 0;
        mem_word = 32'hCAFE_F00D;
        run_txn(0, 1'b0, 32'h0000_0504, 32'h0, 4'b0000, 1'b0, cyc, ok, rd);
        check("post_rst_latency", 32'(cyc), 32'd4);
        check("post_rst_rdata", rd, 32'hCAFE_F00D);
        check("post_rst_arprot", 32'(cap_arprot), 32'd0);
        repeat (2) tick();

        // m0 drops valid right after grant: transaction still completes
        mem_word = 32'h0BAD_F00D;
        s0 = m0_rdy_cnt;
        run_txn(0, 1'b0, 32'h0000_0600, 32'h0, 4'b0000, 1'b1, cyc, ok, rd);
        check("drop_done", 32'(ok), 32'd1);
        check("drop_rdata", rd, 32'h0BAD_F00D);
        repeat (5) tick();
        check("drop_pulses", 32'(m0_rdy_cnt - s0), 32'd1);
        check("drop_arvalid_idle", 32'(mem_axi_arvalid), 32'd0);
        mem_word = 32'h7777_0001;
        run_txn(1, 1'b0, 32'h0000_0700, 32'h0, 4'b0000, 1'b0, cyc, ok, rd);
        check("drop_next_latency", 32'(cyc), 32'd4);
        check("drop_next_rdata", rd, 32'h7777_0001);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_mem_arb2.md
AXI_MEM_ARB2 -- requirements
Module: axi_mem_arb2

Interface
REQ-001 SHALL have parameter INSN_PROT, default 1: when 1, arprot = {mN_mem_instr,2'b00}; when 0, arprot = 3'b000.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports m0_mem_valid, m1_mem_valid  input  1  request; held until ready.
REQ-005 SHALL have ports m0_mem_instr, m1_mem_instr  input  1  instruction-fetch flag.
REQ-006 SHALL have ports m0_mem_addr, m1_mem_addr  input  32  byte address.
REQ-007 SHALL have ports m0_mem_wdata, m1_mem_wdata  input  32  write data.
REQ-008 SHALL have ports m0_mem_wstrb, m1_mem_wstrb  input  4  byte enables; 0 = read.
REQ-009 SHALL have ports m0_mem_ready, m1_mem_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_mem_rdata, m1_mem_rdata  output  32  read data, valid with ready.
REQ-011 SHALL have ports mem_axi_awvalid/awready  output/input  1  write address handshake.
REQ-012 SHALL have ports mem_axi_awaddr  output  32, mem_axi_awprot  output  3 (always 3'b000).
REQ-013 SHALL have ports mem_axi_wvalid/wready  output/input  1; mem_axi_wdata output 32; mem_axi_wstrb output 4.
REQ-014 SHALL have ports mem_axi_bvalid/bready  input/output  1  write response.
REQ-015 SHALL have ports mem_axi_arvalid/arready  output/input  1; mem_axi_araddr output 32; mem_axi_arprot output 3.
REQ-016 SHALL have ports mem_axi_rvalid/rready  input/output  1; mem_axi_rdata input 32.

Function
REQ-017 SHALL allow exactly one outstanding AXI transaction; FSM states IDLE, WR, WR_RESP, RD, RD_RESP, DONE.
REQ-018 IDLE: any mN_mem_valid SHALL register grant, latch addr/wdata/wstrb/instr, go to WR if wstrb!=0 else RD; AXI valids rise the next cycle.
REQ-019 WR: awvalid and wvalid SHALL assert together, each drop independently on its own handshake; both done -> WR_RESP (same-cycle acceptance allowed).
REQ-020 WR_RESP: bready SHALL be 1; bvalid -> DONE. RD: arvalid until arready -> RD_RESP; rready=1; rvalid -> latch rdata, DONE.
REQ-021 DONE: granted mN_mem_ready SHALL pulse exactly one cycle with rdata (reads) and FSM returns to IDLE; other requester's ready stays 0.
REQ-022 Minimum latency (zero-wait slave) SHALL be 4 cycles valid-to-ready; AXI address/data/strb SHALL be stable while valid is high.
REQ-023 Requester dropping valid mid-transaction SHALL NOT abort; transaction completes and ready still pulses.
REQ-024 Simultaneous requests: arbitration per REQ-029; loser waits, never starved beyond one transaction in RR mode.
REQ-025 m*_mem_rdata SHALL hold last read value between transactions; non-granted rdata equals shared register (qualified only by ready).

Reset
REQ-026 resetn low SHALL asynchronously force IDLE, all AXI valid/ready outputs 0, mN_mem_ready 0, rdata 0, RR pointer to requester 0.
REQ-027 Reset mid-transaction SHALL abandon the AXI transaction; no ready pulse after release.

Configuration
REQ-028 Macro AXI_ARB_RR_EN SHALL select arbitration mode.
REQ-029 Defined: round-robin; pointer flips to the other requester after each grant. Undefined: fixed priority, requester 0 always wins.

Structure
REQ-030 Package axi_arb_pkg SHALL hold FSM state enum, PROT_INSN/PROT_DATA constants, ADDR_W=32, DATA_W=32.
REQ-031 Sub-module axi_arb_rr (2-way grant picker, pointer register, macro-dependent) SHALL be instantiated once.

Verification
REQ-032 m0 read 0x0000_0100 alone, slave zero-wait, mem=0xDEADBEEF -> m0_mem_ready at cycle 4, rdata 0xDEADBEEF, arprot 3'b100 when instr=1.
REQ-033 m1 write 0x0000_0040, wdata 0x12345678, wstrb 4'b0011, awready delayed 3 cycles, wready immediate -> one aw, one w, m1_mem_ready once after bvalid.
REQ-034 m0 and m1 both valid continuously, AXI_ARB_RR_EN defined -> grants alternate 0,1,0,1; undefined -> m1 never granted while m0 valid.
REQ-035 resetn low during RD_RESP -> arvalid/rready 0 immediately, no ready pulse; next read after release completes normally.
REQ-036 m0 drops valid after grant -> transaction finishes, m0_mem_ready pulses once, FSM back in IDLE.
